// File: rtl/bf_relax_sequencer.sv
// Bellman-Ford relaxation sequencer for a 16-node graph: scans the 16x16 weight
// RAM one edge per cycle, keeps distances in registers, flags negative cycles.
module bf_relax_sequencer #(
  parameter int W_WIDTH = 16,
  parameter int D_WIDTH = 24
) (
  input  logic               Bus2IP_Clk,
  input  logic               Bus2IP_Reset,
  input  logic               start,
  input  logic [3:0]         src,
  output logic               w_en,
  output logic [7:0]         w_addr,
  input  logic [W_WIDTH-1:0] w_data,
  output logic               busy,
  output logic               done,
  output logic               neg_cycle,
  output logic               ovf,
  output logic [3:0]         pass_cnt,
  input  logic [3:0]         rd_idx,
  output logic [D_WIDTH-1:0] rd_dist
);

  localparam logic [W_WIDTH-1:0]        NO_EDGE = {1'b1, {(W_WIDTH-1){1'b0}}};
  localparam logic [D_WIDTH-1:0]        INF     = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [D_WIDTH:0]   SUM_MIN = {2'b11, {(D_WIDTH-1){1'b0}}};
  localparam logic signed [D_WIDTH:0]   SUM_INF = {2'b00, {(D_WIDTH-1){1'b1}}};
  localparam logic [3:0]                DETECT_PASS = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_SCAN = 3'd2,
    S_LAST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [D_WIDTH-1:0]    r_dist [16];
  logic [7:0]            r_cnt;
  logic [3:0]            r_pass;
  logic [3:0]            r_src;
  logic                  r_neg;
  logic                  r_ovf;
  logic                  r_upd;
  logic                  r_eval_vld;
  logic [7:0]            r_eval_addr;

  logic [3:0]            w_u;
  logic [3:0]            w_v;
  logic [D_WIDTH-1:0]    w_du;
  logic [D_WIDTH-1:0]    w_dv;
  logic signed [D_WIDTH:0] w_dv_ext;
  logic signed [D_WIDTH:0] w_w_ext;
  logic signed [D_WIDTH:0] w_sum_raw;
  logic signed [D_WIDTH:0] w_sum;
  logic                  w_skip;
  logic                  w_clamp;
  logic                  w_cand;
  logic                  w_relax;
  logic                  w_detect;
  logic                  w_upd_any;

  assign w_en      = (r_state == S_SCAN);
  assign w_addr    = r_cnt;
  assign busy      = (r_state == S_INIT) || (r_state == S_SCAN) || (r_state == S_LAST);
  assign done      = (r_state == S_DONE);
  assign neg_cycle = r_neg;
  assign ovf       = r_ovf;
  assign pass_cnt  = r_pass;
  assign rd_dist   = r_dist[rd_idx];

  // Edge evaluation one cycle behind the address that fetched its weight.
  always_comb begin
    w_u       = r_eval_addr[7:4];
    w_v       = r_eval_addr[3:0];
    w_du      = r_dist[w_u];
    w_dv      = r_dist[w_v];
    w_dv_ext  = $signed({w_dv[D_WIDTH-1], w_dv});
    w_w_ext   = $signed({{(D_WIDTH+1-W_WIDTH){w_data[W_WIDTH-1]}}, w_data});
    w_sum_raw = $signed({w_du[D_WIDTH-1], w_du}) + w_w_ext;
    w_skip    = (w_data == NO_EDGE) || (w_du == INF);
    w_sum     = w_sum_raw;
    w_clamp   = 1'b0;
    w_cand    = 1'b0;
    if (r_eval_vld && !w_skip) begin
      if (w_sum_raw < SUM_MIN) begin
        w_sum   = SUM_MIN;
        w_clamp = 1'b1;
      end else begin
        w_sum   = w_sum_raw;
      end
      w_cand = (w_sum < w_dv_ext) && (w_sum < SUM_INF);
    end else begin
      w_cand = 1'b0;
    end
    w_relax   = w_cand && (r_pass != DETECT_PASS);
    w_detect  = w_cand && (r_pass == DETECT_PASS);
    w_upd_any = r_upd || w_relax;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_INIT;
        else       w_state_nxt = S_IDLE;
      end
      S_INIT: w_state_nxt = S_SCAN;
      S_SCAN: begin
        if (r_cnt == 8'd255) w_state_nxt = S_LAST;
        else                 w_state_nxt = S_SCAN;
      end
      S_LAST: begin
        if (r_pass == DETECT_PASS) w_state_nxt = S_DONE;
        else if (w_upd_any)        w_state_nxt = S_SCAN;
        else                       w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Distance array, pass bookkeeping and status flags.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      for (int i = 0; i < 16; i++) r_dist[i] <= INF;
      r_cnt       <= 8'd0;
      r_pass      <= 4'd0;
      r_src       <= 4'd0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_upd       <= 1'b0;
      r_eval_vld  <= 1'b0;
      r_eval_addr <= 8'd0;
    end else begin
      r_eval_vld  <= (r_state == S_SCAN);
      r_eval_addr <= r_cnt;
      case (r_state)
        S_IDLE: begin
          if (start) r_src <= src;
        end
        S_INIT: begin
          for (int i = 0; i < 16; i++) r_dist[i] <= INF;
          r_dist[r_src] <= {D_WIDTH{1'b0}};
          r_cnt  <= 8'd0;
          r_pass <= 4'd0;
          r_neg  <= 1'b0;
          r_ovf  <= 1'b0;
          r_upd  <= 1'b0;
        end
        S_SCAN, S_LAST: begin
          if (w_clamp)  r_ovf <= 1'b1;
          if (w_detect) r_neg <= 1'b1;
          if (w_relax) begin
            r_dist[w_v] <= w_sum[D_WIDTH-1:0];
            r_upd       <= 1'b1;
          end
          if (r_state == S_SCAN) begin
            r_cnt <= r_cnt + 8'd1;
          end else if (r_pass != DETECT_PASS) begin
            // Relax pass end: either restart the scan or finish with no cycle.
            r_upd <= 1'b0;
            if (w_upd_any) r_pass <= r_pass + 4'd1;
            else           r_neg  <= 1'b0;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule
